adc_multi_readout: RTL and testbench

//  Parametrised multi-channel readout controller for AD7643-class serial-slave ADCs; generalises the single-channel lx1==5 sequencer.

---
 rtl/adc_multi_readout_if.sv | 11 +
 rtl/adc_multi_readout.sv | 216 +++++++++++++++++++++
 tb/tb_adc_multi_readout.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_multi_readout_if.sv
// Sample stream leaving the readout FIFO: {channel tag, sample} with valid/ready handshake.
interface adc_multi_readout_if #(
    parameter int DATA_W = 18
);
    logic [4+DATA_W-1:0] dout;
    logic                dvalid;
    logic                dready;

    modport master (output dout, output dvalid, input dready);
    modport slave  (input dout, input dvalid, output dready);
endinterface

// File: rtl/adc_multi_readout.sv
// Multi-channel AD7643-class readout: shared CNVST/CS/SCLK, parallel serial capture,
// per-frame all-or-nothing commit into a first-word-fall-through FIFO.
module adc_multi_readout #(
    parameter int NCH        = 2,
    parameter int DATA_W     = 18,
    parameter int SCLK_HALF  = 3,
    parameter int CNV_LOW    = 5,
    parameter int BUSY_TO    = 255,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   run_i,
    input  logic [15:0]            period_i,
    output logic                   adcnvst_o,
    output logic                   adcs_o,
    output logic                   adsclk_o,
    input  logic [NCH-1:0]         adbusy_i,
    input  logic [NCH-1:0]         adsdout_i,
    adc_multi_readout_if.master    m_if,
    output logic                   overflow_o,
    output logic                   timeout_o,
    output logic [15:0]            frames_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(SCLK_HALF + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int WW = 4 + DATA_W;

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_WAITB, S_SHIFT, S_PUSH, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [15:0]     tmr_q, tmr_d;
    logic [15:0]     per_q, per_d;
    logic [HW-1:0]   hc_q, hc_d;
    logic            ph_q, ph_d;
    logic [BW-1:0]   bc_q, bc_d;
    logic [3:0]      idx_q, idx_d;
    logic            ovf_q, ovf_d;
    logic            to_q, to_d;
    logic [15:0]     frames_q, frames_d;

    logic [DATA_W-1:0] sr_q [NCH];
    logic [WW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;

    logic              shift_en, fifo_wr, fifo_rd, space_ok, hold_done;
    logic [DATA_W-1:0] wr_sample;
    logic [WW-1:0]     wr_data;

    // A same-cycle pop is deliberately ignored here, so the frame either fits entirely or not at all.
    assign space_ok  = cnt_q <= CW'(FIFO_DEPTH - NCH);
    assign hold_done = ({1'b0, per_q} + 17'd1) >= {1'b0, period_i};
    assign fifo_rd   = (cnt_q != '0) && m_if.dready;

    always_comb begin
        wr_sample = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx_q == 4'(i)) wr_sample = sr_q[i];
        end
    end
    assign wr_data = {idx_q, wr_sample};

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + 16'd1;
        per_d    = (per_q == 16'hFFFF) ? per_q : per_q + 16'd1;
        hc_d     = hc_q;
        ph_d     = ph_q;
        bc_d     = bc_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        to_d     = to_q;
        frames_d = frames_q;
        shift_en = 1'b0;
        fifo_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i || run_i) begin
                    state_d = S_CONV;
                    tmr_d   = '0;
                    per_d   = '0;
                end
            end
            S_CONV: begin
                if (tmr_q == 16'(CNV_LOW - 1)) begin
                    state_d = S_WAITB;
                    tmr_d   = '0;
                end
            end
            S_WAITB: begin
                // BUSY is ignored for two cycles so a slow rising edge is not mistaken for done.
                if (tmr_q >= 16'd2 && adbusy_i == '0) begin
                    state_d = S_SHIFT;
                    hc_d    = '0;
                    ph_d    = 1'b1;
                    bc_d    = '0;
                end else if (tmr_q == 16'(BUSY_TO - 1)) begin
                    to_d    = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_SHIFT: begin
                if (hc_q == HW'(SCLK_HALF - 1)) begin
                    hc_d = '0;
                    ph_d = !ph_q;
                    if (ph_q) begin
                        shift_en = 1'b1;
                    end else if (bc_q == BW'(DATA_W - 1)) begin
                        state_d = S_PUSH;
                        idx_d   = '0;
                    end else begin
                        bc_d = bc_q + BW'(1);
                    end
                end else begin
                    hc_d = hc_q + HW'(1);
                end
            end
            S_PUSH: begin
                if (idx_q == 4'd0 && !space_ok) begin
                    ovf_d   = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    fifo_wr = 1'b1;
                    if (idx_q == 4'(NCH - 1)) begin
                        frames_d = frames_q + 16'd1;
                        state_d  = S_HOLD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_done) begin
                    if (run_i) begin
                        state_d = S_CONV;
                        tmr_d   = '0;
                        per_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            per_q    <= '0;
            hc_q     <= '0;
            ph_q     <= 1'b0;
            bc_q     <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            per_q    <= per_d;
            hc_q     <= hc_d;
            ph_q     <= ph_d;
            bc_q     <= bc_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            frames_q <= frames_d;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_sr
        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q[gi] <= '0;
            end else if (shift_en) begin
                sr_q[gi] <= {sr_q[gi][DATA_W-2:0], adsdout_i[gi]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign m_if.dvalid = cnt_q != '0;
    assign m_if.dout   = (cnt_q != '0) ? mem[rd_ptr_q] : '0;

    assign adcnvst_o  = state_q != S_CONV;
    assign adcs_o     = state_q != S_SHIFT;
    assign adsclk_o   = (state_q == S_SHIFT) && ph_q;
    assign overflow_o = ovf_q;
    assign timeout_o  = to_q;
    assign frames_o   = frames_q;
endmodule

// File: tb/tb_adc_multi_readout.sv
// Bench: behavioural ADC front-end and frame-level reference model feeding a word
// scoreboard; a separate monitor checks every accepted output word.
module tb_adc_multi_readout;
    localparam int NCH        = 2;
    localparam int DATA_W     = 18;
    localparam int SCLK_HALF  = 3;
    localparam int CNV_LOW    = 5;
    localparam int BUSY_TO    = 255;
    localparam int FIFO_DEPTH = 16;
    // Frame length when BUSY never rises: CONV + 3-cycle WAITB + SHIFT + PUSH + 1-cycle HOLD.
    localparam int FRAME_MIN  = CNV_LOW + 3 + 2 * SCLK_HALF * DATA_W + NCH + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              run = 1'b0;
    logic [15:0]       period = 16'd1;
    logic              adcnvst, adcs, adsclk;
    logic [NCH-1:0]    adbusy = '0;
    logic [NCH-1:0]    adsdout = '0;
    logic              overflow, timeout;
    logic [15:0]       frames;

    adc_multi_readout_if #(.DATA_W(DATA_W)) s_if ();

    adc_multi_readout #(
        .NCH(NCH), .DATA_W(DATA_W), .SCLK_HALF(SCLK_HALF),
        .CNV_LOW(CNV_LOW), .BUSY_TO(BUSY_TO), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .run_i(run), .period_i(period),
        .adcnvst_o(adcnvst), .adcs_o(adcs), .adsclk_o(adsclk),
        .adbusy_i(adbusy), .adsdout_i(adsdout), .m_if(s_if),
        .overflow_o(overflow), .timeout_o(timeout), .frames_o(frames)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [4+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]   smp[NCH];
    int                  busy_cnt[NCH];
    int  cyc = 0, bitk = DATA_W, low_cnt = 0, fall_cnt = 0;
    int  last_fall_cyc = 0, last_fall_run = -1, rise_cyc = 0;
    int  run_id = 0, exp_spacing = 0, busy_max = 60, nfall = 0;
    int  pushed_words = 0, popped_words = 0;
    bit  fixed_mode = 0, force_busy = 0, exp_ovf = 0, exp_to = 0;
    bit  rand_ready = 0, ready_lvl = 0;
    logic [15:0] frames_exp = '0;
    logic prev_cnvst = 1'b1, prev_cs = 1'b1, prev_sclk = 1'b0, prev_to = 1'b0;

    initial for (int i = 0; i < NCH; i++) begin
        busy_cnt[i] = 0;
        smp[i] = '0;
    end

    // ADC front-end and frame-level prediction, evaluated just after each clock edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = 0; i < NCH; i++) if (busy_cnt[i] > 0) busy_cnt[i]--;
        if (prev_cnvst && !adcnvst && !rst) begin
            nfall++;
            if (exp_spacing != 0 && last_fall_run == run_id)
                check("cnvst_spacing", 64'(cyc - last_fall_cyc), 64'(exp_spacing));
            last_fall_cyc = cyc;
            last_fall_run = run_id;
            low_cnt = 0;
            for (int i = 0; i < NCH; i++) begin
                if (fixed_mode) smp[i] = (i == 0) ? 18'h2AAAA : 18'h15555;
                else            smp[i] = DATA_W'($urandom);
                busy_cnt[i] = force_busy ? 32'h3FFF_FFFF : int'($urandom_range(busy_max, 0));
            end
            if (force_busy) begin
                exp_to = 1;
            end else if (pushed_words - popped_words + NCH <= FIFO_DEPTH) begin
                for (int i = 0; i < NCH; i++) exp_q.push_back({4'(i), smp[i]});
                pushed_words += NCH;
                frames_exp++;
            end else begin
                exp_ovf = 1;
            end
        end
        for (int i = 0; i < NCH; i++) adbusy[i] = busy_cnt[i] != 0;
        if (!adcnvst) low_cnt++;
        if (!prev_cnvst && adcnvst && !rst) begin
            check("cnvst_low_cycles", 64'(low_cnt), 64'(CNV_LOW));
            rise_cyc = cyc;
        end
        if (prev_cs && !adcs) begin
            bitk = 0;
            fall_cnt = 0;
        end
        if (prev_sclk && !adsclk) begin
            bitk++;
            fall_cnt++;
        end
        if (!prev_cs && adcs && !rst) check("sclk_falls_per_frame", 64'(fall_cnt), 64'(DATA_W));
        if (!prev_to && timeout) check("timeout_wait_cycles", 64'(cyc - rise_cyc), 64'(BUSY_TO));
        for (int i = 0; i < NCH; i++) adsdout[i] = (bitk < DATA_W) ? smp[i][DATA_W-1-bitk] : 1'b0;
        prev_cnvst = adcnvst;
        prev_cs    = adcs;
        prev_sclk  = adsclk;
        prev_to    = timeout;
    end

    // Monitor: every accepted word is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && s_if.dvalid && s_if.dready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%0h expected none", s_if.dout);
            end else begin
                check("dout_word", 64'(s_if.dout), 64'(exp_q.pop_front()));
                popped_words++;
            end
        end
    end

    initial begin
        s_if.dready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            s_if.dready = rand_ready ? 1'($urandom_range(1, 0)) : ready_lvl;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic run_frames(input int n, input int per, input int spacing);
        int target, budget;
        run_id++;
        period = 16'(per);
        exp_spacing = spacing;
        target = nfall + n;
        budget = n * (per + 400) + 1000;
        @(posedge clk); #2 run = 1'b1;
        while (nfall < target && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        if (budget == 0) check("run_frames_budget", 64'(nfall), 64'(target));
        run = 1'b0;
        wait_cycles(per + 400);
        exp_spacing = 0;
    endtask

    initial begin
        int p, budget;
        repeat (3) @(posedge clk);
        #1;
        check("reset_adcnvst", 64'(adcnvst), 64'(1));
        check("reset_adcs", 64'(adcs), 64'(1));
        check("reset_adsclk", 64'(adsclk), 64'(0));
        check("reset_dvalid", 64'(s_if.dvalid), 64'(0));
        check("reset_dout", 64'(s_if.dout), 64'(0));
        check("reset_overflow", 64'(overflow), 64'(0));
        check("reset_timeout", 64'(timeout), 64'(0));
        check("reset_frames", 64'(frames), 64'(0));
        #1 rst = 1'b0;

        // Single shot with fixed patterns, consumer always ready.
        fixed_mode = 1; ready_lvl = 1; rand_ready = 0;
        pulse_start();
        wait_cycles(300);
        fixed_mode = 0;
        check("t1_frames", 64'(frames), 64'(1));
        check("t1_drained", 64'(exp_q.size()), 64'(0));

        // Periodic frames with a random-stall consumer.
        rand_ready = 1;
        run_frames(10, 400, 400);
        check("t2_frames", 64'(frames), 64'(frames_exp));
        for (int k = 0; k < 3; k++) begin
            p = int'($urandom_range(400, 200));
            run_frames(4, p, p);
        end
        check("rand_frames", 64'(frames), 64'(frames_exp));

        // Back-to-back frames: spacing equals the natural frame length.
        busy_max = 0;
        run_frames(5, 1, FRAME_MIN);
        busy_max = 60;
        check("t6_frames", 64'(frames), 64'(frames_exp));
        wait_cycles(50);
        check("t6_drained", 64'(exp_q.size()), 64'(0));

        // Stalled consumer until the FIFO cannot take a whole frame.
        rand_ready = 0; ready_lvl = 0;
        run_frames(9, 300, 300);
        check("t3_overflow", 64'(overflow), 64'(exp_ovf));
        check("t3_overflow_set", 64'(overflow), 64'(1));
        check("t3_dvalid", 64'(s_if.dvalid), 64'(1));
        check("t3_frames", 64'(frames), 64'(frames_exp));
        ready_lvl = 1;
        wait_cycles(100);
        check("t3_drained", 64'(exp_q.size()), 64'(0));
        check("t3_empty_after_drain", 64'(s_if.dvalid), 64'(0));

        // BUSY stuck high.
        force_busy = 1;
        pulse_start();
        wait_cycles(600);
        force_busy = 0;
        check("t4_timeout", 64'(timeout), 64'(exp_to));
        check("t4_timeout_set", 64'(timeout), 64'(1));
        check("t4_no_write", 64'(s_if.dvalid), 64'(0));
        check("t4_frames", 64'(frames), 64'(frames_exp));

        // Reset in the middle of the serial shift.
        pulse_start();
        budget = 2000;
        while (adcs && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("t5_shift_budget", 64'(adcs), 64'(0));
        wait_cycles(20);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("t5_adcs", 64'(adcs), 64'(1));
        check("t5_adsclk", 64'(adsclk), 64'(0));
        check("t5_adcnvst", 64'(adcnvst), 64'(1));
        check("t5_dvalid", 64'(s_if.dvalid), 64'(0));
        check("t5_frames", 64'(frames), 64'(0));
        check("t5_overflow", 64'(overflow), 64'(0));
        check("t5_timeout", 64'(timeout), 64'(0));
        #1 rst = 1'b0;
        exp_q.delete();
        pushed_words = popped_words;
        frames_exp = '0;
        exp_ovf = 0;
        exp_to = 0;
        pulse_start();
        wait_cycles(300);
        check("t5_frames_after", 64'(frames), 64'(1));
        check("t5_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
